// File: rtl/dmem_uart_tx.sv
// dmem_uart_tx: memory-mapped UART transmitter (TXDATA/STATUS window, TX FIFO, 8N1 serializer).
// Define DMEM_UART_TX_PARITY_EN for 8E1 framing (extra even-parity bit-time).
module dmem_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'hFFFF_FFE0,
  parameter int          CLKS_PER_BIT = 104,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  funct3,
  input  logic        dmem_wren,
  input  logic [31:0] dmem_address,
  input  logic [31:0] dmem_data_in,
  output logic [31:0] dmem_data_out,
  output logic        uart_tx
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(FIFO_DEPTH);
`ifdef DMEM_UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, PARITY} state_e;
  logic par_q;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;
`endif
  state_e        state_q;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic [BW-1:0] baud_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic          tx_q;
  logic [31:0]   rdata_q, rdata_d;
  logic          hit, wr_tx, wr_st, empty, full, baud_end, pop, push;
  logic [7:0]    head;
  logic [31:0]   status;
  logic          unused_ok;
  assign hit      = dmem_address[31:3] == BASE_ADDR[31:3];
  assign wr_tx    = dmem_wren & hit & (dmem_address[2:0] == 3'd0);
  assign wr_st    = dmem_wren & hit & (dmem_address[2:0] == 3'd4);
  assign empty    = cnt_q == '0;
  assign full     = cnt_q == FULL_CNT;
  assign baud_end = baud_q == BAUD_LAST;
  assign head     = mem_q[rd_q];
  // Pops only happen when leaving IDLE or at the last cycle of a stop bit.
  assign pop      = !empty & ((state_q == IDLE) | ((state_q == STOP) & baud_end));
  assign push     = wr_tx & (!full | pop);
  assign cnt_d    = cnt_q + (AW + 1)'(push) - (AW + 1)'(pop);
  assign ovf_d    = (wr_tx & full & !pop) | (ovf_q & !(wr_st & dmem_data_in[3]));
  assign status   = {24'd0, 4'(cnt_q), ovf_q, state_q != IDLE, empty, full};
  assign rdata_d  = (hit & (dmem_address[2:0] == 3'd4)) ? status : 32'd0;
  assign unused_ok = ^{funct3, dmem_data_in[31:8]};
  assign dmem_data_out = rdata_q;
  assign uart_tx       = tx_q;
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= dmem_data_in[7:0];
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop) rd_q <= rd_q + 1'b1;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      rdata_q <= rdata_d;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
`ifdef DMEM_UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      baud_q <= ((state_q == IDLE) | baud_end) ? '0 : baud_q + 1'b1;
      if (pop) begin
        shift_q <= head;
        bit_q   <= '0;
`ifdef DMEM_UART_TX_PARITY_EN
        par_q   <= ^head;
`endif
      end
      case (state_q)
        IDLE: if (pop) begin
          state_q <= START;
          tx_q    <= 1'b0;
        end
        START: if (baud_end) begin
          state_q <= DATA;
          tx_q    <= shift_q[0];
        end
        DATA: if (baud_end) begin
          if (bit_q == 3'd7) begin
`ifdef DMEM_UART_TX_PARITY_EN
            state_q <= PARITY;
            tx_q    <= par_q;
`else
            state_q <= STOP;
            tx_q    <= 1'b1;
`endif
          end else begin
            bit_q   <= bit_q + 1'b1;
            shift_q <= shift_q >> 1;
            tx_q    <= shift_q[1];
          end
        end
`ifdef DMEM_UART_TX_PARITY_EN
        PARITY: if (baud_end) begin
          state_q <= STOP;
          tx_q    <= 1'b1;
        end
`endif
        STOP: if (baud_end) begin
          state_q <= pop ? START : IDLE;
          tx_q    <= !pop;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_uart_tx.sv
// tb_dmem_uart_tx: directed bench for dmem_uart_tx (CLKS_PER_BIT=4, FIFO_DEPTH=8).
module tb_dmem_uart_tx;
  localparam logic [31:0] BASE = 32'hFFFF_FFE0;
`ifdef DMEM_UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  localparam int L = FB * 4;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [2:0]  funct3 = 3'd2;
  logic        dmem_wren = 1'b0;
  logic [31:0] dmem_address = 32'd0;
  logic [31:0] dmem_data_in = 32'd0;
  logic [31:0] dmem_data_out;
  logic        uart_tx;
  int          checks = 0;
  int          errors = 0;
  logic        low_seen;

  dmem_uart_tx #(.BASE_ADDR(BASE), .CLKS_PER_BIT(4), .FIFO_DEPTH(8)) dut (
    .clk(clk), .reset(reset), .funct3(funct3), .dmem_wren(dmem_wren),
    .dmem_address(dmem_address), .dmem_data_in(dmem_data_in),
    .dmem_data_out(dmem_data_out), .uart_tx(uart_tx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [FB-1:0] frame(input logic [7:0] b);
`ifdef DMEM_UART_TX_PARITY_EN
    return {1'b1, ^b, b, 1'b0};
`else
    return {1'b1, b, 1'b0};
`endif
  endfunction

  // Checks the line at the current negedge and the next L-1, ends one negedge past the frame.
  task automatic expect_frame(input logic [7:0] b, input logic [31:0] st);
    logic [FB-1:0] f;
    f = frame(b);
    for (int k = 0; k < L; k++) begin
      chk($sformatf("bit%0d_of_%02h", k / 4, b), {31'd0, uart_tx}, {31'd0, f[k/4]});
      if (k == 20) chk($sformatf("mid_status_%02h", b), dmem_data_out, st);
      @(negedge clk);
    end
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    dmem_wren = 1'b1;
    dmem_address = a;
    dmem_data_in = d;
    @(negedge clk);
    dmem_wren = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_tx", {31'd0, uart_tx}, 32'd1);
    chk("rst_dout", dmem_data_out, 32'd0);
    reset = 1'b1;
    dmem_address = BASE + 32'd4;
    @(negedge clk);
    chk("rst_status", dmem_data_out, 32'h02);
    // Stores outside the TXDATA slot must be ignored.
    store(BASE + 32'd2, 32'hFF);
    store(BASE + 32'd8, 32'hEE);
    dmem_address = BASE + 32'd4;
    @(negedge clk);
    chk("stray_status", dmem_data_out, 32'h02);
    chk("stray_tx", {31'd0, uart_tx}, 32'd1);
    dmem_address = BASE;
    @(negedge clk);
    chk("txdata_load", dmem_data_out, 32'd0);
    // Single frame.
    store(BASE, 32'h1234_56A5);
    dmem_address = BASE + 32'd4;
    chk("pre_start_tx", {31'd0, uart_tx}, 32'd1);
    @(negedge clk);
    expect_frame(8'hA5, 32'h06);
    @(negedge clk);
    chk("single_done", dmem_data_out, 32'h02);
    // Fill and overflow.
    dmem_wren = 1'b1;
    dmem_address = BASE;
    for (int i = 0; i < 10; i++) begin
      dmem_data_in = i;
      @(negedge clk);
    end
    dmem_wren = 1'b0;
    dmem_address = BASE + 32'd4;
    @(negedge clk);
    chk("ovf_status", dmem_data_out, 32'h8D);
    dmem_wren = 1'b1;
    dmem_data_in = 32'hFFFF_FFF7;
    @(negedge clk);
    dmem_data_in = 32'h8;
    @(negedge clk);
    chk("ovf_kept", dmem_data_out, 32'h8D);
    dmem_wren = 1'b0;
    @(negedge clk);
    chk("ovf_cleared", dmem_data_out, 32'h85);
    repeat (L - 12) @(negedge clk);
    for (int b = 1; b <= 8; b++)
      expect_frame(8'(b), ((32'(8 - b)) << 4) | 32'h04 | ((b == 8) ? 32'h02 : 32'h00));
    @(negedge clk);
    chk("fill_done", dmem_data_out, 32'h02);
    // Back-to-back streaming.
    dmem_wren = 1'b1;
    dmem_address = BASE;
    dmem_data_in = 32'h41;
    @(negedge clk);
    dmem_data_in = 32'h42;
    @(negedge clk);
    dmem_wren = 1'b0;
    dmem_address = BASE + 32'd4;
    expect_frame(8'h41, 32'h14);
    expect_frame(8'h42, 32'h06);
    @(negedge clk);
    chk("b2b_done", dmem_data_out, 32'h02);
    // Reset mid-frame with a second byte still queued.
    dmem_wren = 1'b1;
    dmem_address = BASE;
    dmem_data_in = 32'h55;
    @(negedge clk);
    dmem_data_in = 32'h66;
    @(negedge clk);
    dmem_wren = 1'b0;
    dmem_address = BASE + 32'd4;
    repeat (9) @(negedge clk);
    chk("mid_frame_low", {31'd0, uart_tx}, 32'd0);
    #2 reset = 1'b0;
    #1;
    chk("async_tx", {31'd0, uart_tx}, 32'd1);
    chk("async_dout", dmem_data_out, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_status", dmem_data_out, 32'h02);
    low_seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (!uart_tx) low_seen = 1'b1;
      @(negedge clk);
    end
    chk("no_frame_after_rst", {31'd0, low_seen}, 32'd0);
`ifdef DMEM_UART_TX_PARITY_EN
    store(BASE, 32'h07);
    @(negedge clk);
    expect_frame(8'h07, 32'h06);
    @(negedge clk);
    store(BASE, 32'hA5);
    @(negedge clk);
    expect_frame(8'hA5, 32'h06);
    @(negedge clk);
    chk("parity_done", dmem_data_out, 32'h02);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
